// File: rtl/m_bp_upd_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : m_bp_upd_sched_pkg
// Brief   : Shared widths, FSM encoding and queue entry layout for the
//           gshare update scheduler.
// Revision: 1.0
// ============================================================================
package m_bp_upd_sched_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned CNT_W_DEF  = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_STALL = 2'd2;
    localparam state_t ST_FLUSH = 2'd3;

    // Queue entry is {pc, tk}: outcome bit at the bottom, index above it.
    localparam int unsigned ENT_TK_BIT = 0;
    localparam int unsigned ENT_PC_LSB = 1;

endpackage
`default_nettype wire

// File: rtl/m_bp_upd_sched_fifo.sv
`default_nettype none
// ============================================================================
// Module  : m_upd_fifo
// Brief   : DEPTH-entry circular FIFO, two pushes and one pop per cycle.
// Revision: 1.0
// ============================================================================
module m_upd_fifo
    import m_bp_upd_sched_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned ENT_W = ADDR_W_DEF + 1,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push0_i,
    input  logic [ENT_W-1:0] data0_i,
    input  logic             push1_i,
    input  logic [ENT_W-1:0] data1_i,
    input  logic             pop_i,
    output logic [ENT_W-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] count_next_o
);

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] wr_inc;
    logic [CNT_W-1:0] count_q, count_d;

    assign wr_inc = wr_q + PTR_W'(1);

    always_comb begin
        rd_d    = rd_q + PTR_W'(pop_i);
        wr_d    = wr_q + PTR_W'(push0_i) + PTR_W'(push1_i);
        count_d = count_q + CNT_W'(push0_i) + CNT_W'(push1_i) - CNT_W'(pop_i);
        if (clear_i) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    // Source 1 lands behind source 0 when both push in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!clear_i) begin
            if (push0_i) begin
                mem_q[wr_q] <= data0_i;
            end
            if (push1_i) begin
                mem_q[push0_i ? wr_inc : wr_q] <= data1_i;
            end
        end
    end

    assign head_o       = mem_q[rd_q];
    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule
`default_nettype wire

// File: rtl/m_bp_upd_sched.sv
`default_nettype none
// ============================================================================
// Module  : m_bp_upd_sched
// Brief   : Serialises two branch-resolution streams onto the predictor's
//           single write port; tracks mispredictions.
// Revision: 1.0
// ============================================================================
module m_bp_upd_sched
    import m_bp_upd_sched_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              w_clock,
    input  logic              w_reset,
    input  logic              w_v0,
    input  logic [ADDR_W-1:0] w_pc0,
    input  logic              w_tk0,
    input  logic              w_pd0,
    input  logic              w_v1,
    input  logic [ADDR_W-1:0] w_pc1,
    input  logic              w_tk1,
    input  logic              w_pd1,
    output logic              w_ready,
    input  logic              w_hold,
    input  logic              w_flush,
    output logic [ADDR_W-1:0] w_wa,
    output logic              w_we,
    output logic              w_token,
    output logic              w_busy,
    output logic [CNT_W-1:0]  w_miss_cnt
);

    localparam int unsigned ENT_W  = ADDR_W + 1;
    localparam int unsigned QCNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W  = CNT_W + 1;

    state_t              state_q, state_d;
    logic [QCNT_W-1:0]   count, count_next;
    logic [ENT_W-1:0]    head;
    logic                ready;
    logic                push0, push1, pop;
    logic                we_q;
    logic [ADDR_W-1:0]   wa_q;
    logic                tk_q;
    logic [CNT_W-1:0]    miss_q, miss_d;
    logic [1:0]          miss_inc;
    logic [SUM_W-1:0]    miss_sum;

    m_upd_fifo #(
        .DEPTH (DEPTH),
        .ENT_W (ENT_W)
    ) u_fifo (
        .clk_i        (w_clock),
        .rst_i        (w_reset),
        .clear_i      (w_flush),
        .push0_i      (push0),
        .data0_i      ({w_pc0, w_tk0}),
        .push1_i      (push1),
        .data1_i      ({w_pc1, w_tk1}),
        .pop_i        (pop),
        .head_o       (head),
        .count_o      (count),
        .count_next_o (count_next)
    );

    always_ff @(posedge w_clock) begin
        if (w_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        if (w_flush) begin
            state_d = ST_FLUSH;
        end else if (count_next == '0) begin
            state_d = ST_IDLE;
        end else if (w_hold) begin
            state_d = ST_STALL;
        end else begin
            state_d = ST_ISSUE;
        end
    end

    // Ready demands room for two so neither source ever needs back-pressure alone.
    always_comb begin
        ready = !w_reset && (state_q != ST_FLUSH) && (count <= QCNT_W'(DEPTH - 2));
        push0 = ready && w_v0 && !w_flush;
        push1 = ready && w_v1 && !w_flush;
        pop   = (count != '0) && !w_hold && !w_flush && (state_q != ST_FLUSH);
    end

    always_comb begin
        miss_inc = 2'(push0 && (w_tk0 != w_pd0)) + 2'(push1 && (w_tk1 != w_pd1));
        miss_sum = {1'b0, miss_q} + SUM_W'(miss_inc);
        miss_d   = miss_sum[CNT_W] ? '1 : miss_sum[CNT_W-1:0];
    end

    always_ff @(posedge w_clock) begin
        if (w_reset) begin
            we_q   <= 1'b0;
            wa_q   <= '0;
            tk_q   <= 1'b0;
            miss_q <= '0;
        end else begin
            we_q   <= pop;
            miss_q <= miss_d;
            if (pop) begin
                wa_q <= head[ENT_PC_LSB +: ADDR_W];
                tk_q <= head[ENT_TK_BIT];
            end
        end
    end

    assign w_ready    = ready;
    assign w_we       = we_q;
    assign w_wa       = wa_q;
    assign w_token    = tk_q;
    assign w_busy     = (count != '0) || we_q;
    assign w_miss_cnt = miss_q;

endmodule
`default_nettype wire

// File: tb/tb_m_bp_upd_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_m_bp_upd_sched
// Brief   : Self-checking bench for the update scheduler (16- and 4-bit counters).
// Revision: 1.0
// ============================================================================
module tb_m_bp_upd_sched;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       v0 = 1'b0, tk0 = 1'b0, pd0 = 1'b0;
    logic       v1 = 1'b0, tk1 = 1'b0, pd1 = 1'b0;
    logic [4:0] pc0 = '0, pc1 = '0;
    logic       hold = 1'b0, flush = 1'b0;

    logic        a_ready, a_we, a_tok, a_busy;
    logic [4:0]  a_wa;
    logic [15:0] a_miss;
    logic        b_ready, b_we, b_tok, b_busy;
    logic [4:0]  b_wa;
    logic [3:0]  b_miss;

    wire [24:0] a_vec = {a_ready, a_we, a_wa, a_tok, a_busy, a_miss};
    wire [24:0] b_vec = {b_ready, b_we, b_wa, b_tok, b_busy, 12'd0, b_miss};

    always #5 clk = ~clk;

    m_bp_upd_sched #(.DEPTH(DEPTH), .ADDR_W(5), .CNT_W(16)) dut_a (
        .w_clock(clk), .w_reset(rst),
        .w_v0(v0), .w_pc0(pc0), .w_tk0(tk0), .w_pd0(pd0),
        .w_v1(v1), .w_pc1(pc1), .w_tk1(tk1), .w_pd1(pd1),
        .w_ready(a_ready), .w_hold(hold), .w_flush(flush),
        .w_wa(a_wa), .w_we(a_we), .w_token(a_tok), .w_busy(a_busy), .w_miss_cnt(a_miss)
    );

    m_bp_upd_sched #(.DEPTH(DEPTH), .ADDR_W(5), .CNT_W(4)) dut_b (
        .w_clock(clk), .w_reset(rst),
        .w_v0(v0), .w_pc0(pc0), .w_tk0(tk0), .w_pd0(pd0),
        .w_v1(v1), .w_pc1(pc1), .w_tk1(tk1), .w_pd1(pd1),
        .w_ready(b_ready), .w_hold(hold), .w_flush(flush),
        .w_wa(b_wa), .w_we(b_we), .w_token(b_tok), .w_busy(b_busy), .w_miss_cnt(b_miss)
    );

    // Reference model: a plain queue of {pc,tk} plus the registered issue slot.
    logic [5:0] mq[$];
    bit         m_fl;
    bit         m_we;
    logic [4:0] m_wa;
    bit         m_tk;
    int         m_miss16, m_miss4;

    int n_pass = 0;
    int n_chk  = 0;

    function automatic bit m_ready();
        return !rst && !m_fl && (mq.size() <= DEPTH - 2);
    endfunction

    function automatic logic [24:0] exp_vec(input int miss);
        return {m_ready(), m_we, m_wa, m_tk, (mq.size() != 0) || m_we, 16'(miss)};
    endfunction

    task automatic tick();
        bit         rdy;
        int         n;
        logic [5:0] h;
        rdy = m_ready();
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_fl = 0; m_we = 0; m_wa = '0; m_tk = 0;
            m_miss16 = 0; m_miss4 = 0;
        end else begin
            n = 0;
            if (mq.size() > 0 && !hold && !flush && !m_fl) begin
                h = mq.pop_front();
                m_we = 1; m_wa = h[5:1]; m_tk = h[0];
            end else begin
                m_we = 0;
            end
            if (rdy && !flush) begin
                if (v0) begin mq.push_back({pc0, tk0}); n += int'(tk0 != pd0); end
                if (v1) begin mq.push_back({pc1, tk1}); n += int'(tk1 != pd1); end
            end
            if (flush) mq.delete();
            m_fl = flush;
            m_miss16 = (m_miss16 + n > 65535) ? 65535 : m_miss16 + n;
            m_miss4  = (m_miss4 + n > 15) ? 15 : m_miss4 + n;
        end
        #1;
    endtask

    task automatic idle_inputs();
        v0 = 0; v1 = 0; hold = 0; flush = 0; rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick();
        n_chk++; if (a_ready !== 1'b0) $display("FAIL reset_ready_in_reset: got %b exp 0", a_ready); else n_pass++;
        n_chk++; if ({a_we, a_wa, a_tok, a_busy, a_miss} !== 23'd0)
            $display("FAIL reset_outputs: got we=%b wa=%0d tok=%b busy=%b miss=%0d exp all 0", a_we, a_wa, a_tok, a_busy, a_miss);
        else n_pass++;
        rst = 0;
        #1;
        n_chk++; if (a_ready !== 1'b1) $display("FAIL reset_ready_after: got %b exp 1", a_ready); else n_pass++;
    endtask

    task automatic test_single();
        v0 = 1; pc0 = 5'd5; tk0 = 1; pd0 = 0;
        tick();
        v0 = 0;
        n_chk++; if (a_we !== 1'b0 || a_busy !== 1'b1 || a_miss !== 16'd1)
            $display("FAIL single_after_push: got we=%b busy=%b miss=%0d exp we=0 busy=1 miss=1", a_we, a_busy, a_miss);
        else n_pass++;
        tick();
        n_chk++; if (a_we !== 1'b1 || a_wa !== 5'd5 || a_tok !== 1'b1)
            $display("FAIL single_issue: got we=%b wa=%0d tok=%b exp we=1 wa=5 tok=1", a_we, a_wa, a_tok);
        else n_pass++;
        tick();
        n_chk++; if (a_we !== 1'b0 || a_busy !== 1'b0 || a_wa !== 5'd5)
            $display("FAIL single_done: got we=%b busy=%b wa=%0d exp we=0 busy=0 wa=5", a_we, a_busy, a_wa);
        else n_pass++;
    endtask

    task automatic test_dual();
        v0 = 1; pc0 = 5'd3; tk0 = 0; pd0 = 0;
        v1 = 1; pc1 = 5'd9; tk1 = 1; pd1 = 1;
        tick();
        v0 = 0; v1 = 0;
        tick();
        n_chk++; if (a_we !== 1'b1 || a_wa !== 5'd3 || a_tok !== 1'b0)
            $display("FAIL dual_first: got we=%b wa=%0d tok=%b exp we=1 wa=3 tok=0", a_we, a_wa, a_tok);
        else n_pass++;
        tick();
        n_chk++; if (a_we !== 1'b1 || a_wa !== 5'd9 || a_tok !== 1'b1)
            $display("FAIL dual_second: got we=%b wa=%0d tok=%b exp we=1 wa=9 tok=1", a_we, a_wa, a_tok);
        else n_pass++;
        tick();
        n_chk++; if (a_we !== 1'b0 || a_miss !== 16'd1)
            $display("FAIL dual_done: got we=%b miss=%0d exp we=0 miss=1", a_we, a_miss);
        else n_pass++;
    endtask

    task automatic test_hold_fill();
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            v0 = 1; pc0 = 5'(16 + 2 * i); tk0 = 0; pd0 = 0;
            v1 = 1; pc1 = 5'(17 + 2 * i); tk1 = 1; pd1 = 1;
            tick();
            n_chk++; if (a_ready !== (i == 0) || a_we !== 1'b0 || a_busy !== 1'b1)
                $display("FAIL hold_fill_%0d: got ready=%b we=%b busy=%b exp ready=%0d we=0 busy=1", i, a_ready, a_we, a_busy, i == 0);
            else n_pass++;
        end
        v0 = 0; v1 = 0; hold = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++; if (a_we !== 1'b1 || a_wa !== 5'(16 + i) || a_tok !== 1'(i % 2))
                $display("FAIL hold_drain_%0d: got we=%b wa=%0d tok=%b exp we=1 wa=%0d tok=%0d", i, a_we, a_wa, a_tok, 16 + i, i % 2);
            else n_pass++;
        end
        tick();
        n_chk++; if (a_we !== 1'b0 || a_busy !== 1'b0)
            $display("FAIL hold_drain_end: got we=%b busy=%b exp we=0 busy=0", a_we, a_busy);
        else n_pass++;
    endtask

    task automatic test_flush();
        logic [15:0] miss_before;
        hold = 1;
        v0 = 1; pc0 = 5'd1; tk0 = 1; pd0 = 0;
        v1 = 1; pc1 = 5'd2; tk1 = 0; pd1 = 0;
        tick();
        v1 = 0; pc0 = 5'd3; tk0 = 0; pd0 = 0;
        tick();
        miss_before = 16'(m_miss16);
        flush = 1; v0 = 1; v1 = 1; tk0 = 1; pd0 = 0; tk1 = 0; pd1 = 1;
        tick();
        n_chk++; if (a_we !== 1'b0 || a_ready !== 1'b0 || a_busy !== 1'b0 || a_miss !== miss_before)
            $display("FAIL flush_cycle: got we=%b ready=%b busy=%b miss=%0d exp we=0 ready=0 busy=0 miss=%0d",
                     a_we, a_ready, a_busy, a_miss, miss_before);
        else n_pass++;
        flush = 0; hold = 0; v1 = 0;
        tick();
        n_chk++; if (a_we !== 1'b0 || a_ready !== 1'b1 || a_busy !== 1'b0 || a_miss !== miss_before)
            $display("FAIL flush_after: got we=%b ready=%b busy=%b miss=%0d exp we=0 ready=1 busy=0 miss=%0d",
                     a_we, a_ready, a_busy, a_miss, miss_before);
        else n_pass++;
        v0 = 0;
    endtask

    task automatic test_saturate();
        int acc;
        acc = 0;
        rst = 1; tick(); rst = 0;
        v0 = 1; tk0 = 1; pd0 = 0;
        v1 = 1; tk1 = 0; pd1 = 1;
        for (int i = 0; i < 60 && acc < 8; i++) begin
            pc0 = 5'($urandom); pc1 = 5'($urandom);
            if (m_ready()) acc++;
            tick();
            n_chk++; if (b_vec !== exp_vec(m_miss4))
                $display("FAIL sat_b_cycle%0d: got %h exp %h", i, b_vec, exp_vec(m_miss4));
            else n_pass++;
        end
        v0 = 0; v1 = 0;
        n_chk++; if (acc != 8 || b_miss !== 4'd15 || a_miss !== 16'd16)
            $display("FAIL sat_final: got accepted=%0d b_miss=%0d a_miss=%0d exp accepted=8 b_miss=15 a_miss=16", acc, b_miss, a_miss);
        else n_pass++;
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic test_reset_mid();
        hold = 1;
        v0 = 1; pc0 = 5'd10; tk0 = 0; pd0 = 1;
        v1 = 1; pc1 = 5'd11; tk1 = 0; pd1 = 0;
        tick();
        v1 = 0; pc0 = 5'd12;
        tick();
        v0 = 0; hold = 0;
        tick();
        n_chk++; if (a_we !== 1'b1 || a_wa !== 5'd10 || a_miss == 16'd0)
            $display("FAIL rstmid_pre: got we=%b wa=%0d miss=%0d exp we=1 wa=10 miss!=0", a_we, a_wa, a_miss);
        else n_pass++;
        rst = 1; v0 = 1; v1 = 1; flush = 1; hold = 1;
        tick();
        rst = 0; v1 = 0; flush = 0; hold = 0;
        n_chk++; if (a_we !== 1'b0 || a_miss !== 16'd0 || a_busy !== 1'b0 || b_miss !== 4'd0)
            $display("FAIL rstmid_reset: got we=%b miss=%0d busy=%b bmiss=%0d exp 0 0 0 0", a_we, a_miss, a_busy, b_miss);
        else n_pass++;
        v0 = 1; pc0 = 5'd7; tk0 = 1; pd0 = 1;
        tick();
        v0 = 0;
        tick();
        n_chk++; if (a_we !== 1'b1 || a_wa !== 5'd7 || a_tok !== 1'b1)
            $display("FAIL rstmid_repush: got we=%b wa=%0d tok=%b exp we=1 wa=7 tok=1", a_we, a_wa, a_tok);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 99) < 2);
            flush = ($urandom_range(0, 99) < 6);
            hold  = ($urandom_range(0, 99) < 30);
            v0 = ($urandom_range(0, 99) < 60); pc0 = 5'($urandom); tk0 = 1'($urandom); pd0 = 1'($urandom);
            v1 = ($urandom_range(0, 99) < 60); pc1 = 5'($urandom); tk1 = 1'($urandom); pd1 = 1'($urandom);
            tick();
            n_chk++; if (a_vec !== exp_vec(m_miss16))
                $display("FAIL rand_a_cycle%0d: got %h exp %h", i, a_vec, exp_vec(m_miss16));
            else n_pass++;
            n_chk++; if (b_vec !== exp_vec(m_miss4))
                $display("FAIL rand_b_cycle%0d: got %h exp %h", i, b_vec, exp_vec(m_miss4));
            else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        #2;
        test_reset();
        test_single();
        test_dual();
        test_hold_fill();
        test_flush();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
